// File: rtl/axi_rd_if.sv
// AXI4 read-only (AR + R) channel bundle.
// master: drives AR request and R ready (a read manager, or the arbiter towards memory).
// slave : drives AR ready and R response (memory, or the arbiter towards a manager).
// Ports: arvalid/arready, araddr, arlen, arsize, arburst, arid,
//        rvalid/rready, rdata, rlast, rid, rresp.
interface axi_rd_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 1
);
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [ID_WIDTH-1:0]   arid;

    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rlast;
    logic [ID_WIDTH-1:0]   rid;
    logic [1:0]            rresp;

    modport master (
        output arvalid, araddr, arlen, arsize, arburst, arid, rready,
        input  arready, rvalid, rdata, rlast, rid, rresp
    );

    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst, arid, rready,
        output arready, rvalid, rdata, rlast, rid, rresp
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Two-manager to one-subordinate AXI4 read arbiter. One burst in flight at a time:
// a winner is picked in IDLE (round-robin or m0-priority), its AR is registered
// towards memory (ADDR), then the R channel is passed through combinationally to the
// granted manager until the RLAST beat (DATA).
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   m0, m1      : manager-side read channels (arbiter acts as subordinate)
//   s           : memory-side read channel, ID one bit wider (top bit = manager index)
//   grant       : index of current or last granted manager
//   busy        : burst in progress (ADDR or DATA)
//   rid_err     : sticky, set when a beat returns with an ID top bit != grant
module axi_rd_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ID_WIDTH    = 1,
    parameter int unsigned PRIORITY_M0 = 0
) (
    input  logic     clk,
    input  logic     reset,
    axi_rd_if.slave  m0,
    axi_rd_if.slave  m1,
    axi_rd_if.master s,
    output logic     grant,
    output logic     busy,
    output logic     rid_err
);
    localparam int unsigned SID_WIDTH  = ID_WIDTH + 1;
    localparam bit          FIXED_PRIO = (PRIORITY_M0 != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                 state;
    logic                   s_arvalid_q;
    logic [ADDR_WIDTH-1:0]  s_araddr_q;
    logic [7:0]             s_arlen_q;
    logic [2:0]             s_arsize_q;
    logic [1:0]             s_arburst_q;
    logic [SID_WIDTH-1:0]   s_arid_q;

    logic                   take_c;
    logic                   winner_c;
    logic [ADDR_WIDTH-1:0]  sel_araddr_c;
    logic [7:0]             sel_arlen_c;
    logic [2:0]             sel_arsize_c;
    logic [1:0]             sel_arburst_c;
    logic [ID_WIDTH-1:0]    sel_arid_c;

    logic                   data_phase_c;
    logic                   s_rready_c;
    logic                   r_beat_c;
    logic [DATA_WIDTH-1:0]  rdata_c;

    // Winner selection; reset is gated so no handshake is advertised while held in reset.
    always_comb begin
        take_c   = 1'b0;
        winner_c = 1'b0;
        if ((state == IDLE) && !reset) begin
            if (m0.arvalid && m1.arvalid) begin
                take_c   = 1'b1;
                // Round-robin: whoever was not granted last time gets the tie.
                winner_c = FIXED_PRIO ? 1'b0 : ~grant;
            end else if (m0.arvalid) begin
                take_c   = 1'b1;
                winner_c = 1'b0;
            end else if (m1.arvalid) begin
                take_c   = 1'b1;
                winner_c = 1'b1;
            end
        end
    end

    assign m0.arready = take_c & ~winner_c;
    assign m1.arready = take_c &  winner_c;

    // AR payload of the winning manager.
    always_comb begin
        sel_araddr_c  = m0.araddr;
        sel_arlen_c   = m0.arlen;
        sel_arsize_c  = m0.arsize;
        sel_arburst_c = m0.arburst;
        sel_arid_c    = m0.arid;
        if (winner_c) begin
            sel_araddr_c  = m1.araddr;
            sel_arlen_c   = m1.arlen;
            sel_arsize_c  = m1.arsize;
            sel_arburst_c = m1.arburst;
            sel_arid_c    = m1.arid;
        end
    end

    // Registered AR channel towards memory.
    assign s.arvalid = s_arvalid_q;
    assign s.araddr  = s_araddr_q;
    assign s.arlen   = s_arlen_q;
    assign s.arsize  = s_arsize_q;
    assign s.arburst = s_arburst_q;
    assign s.arid    = s_arid_q;

    // R channel: zero-latency pass-through, steered by grant, only while in DATA.
    assign data_phase_c = (state == DATA);
    assign s_rready_c   = data_phase_c & (grant ? m1.rready : m0.rready);
    assign s.rready     = s_rready_c;
    assign r_beat_c     = data_phase_c & s.rvalid & s_rready_c;

    assign m0.rvalid = data_phase_c & ~grant & s.rvalid;
    assign m1.rvalid = data_phase_c &  grant & s.rvalid;

    // Data, last, resp and low ID bits are broadcast; only rvalid qualifies them.
    assign rdata_c  = s.rdata;
    assign m0.rdata = rdata_c;
    assign m1.rdata = rdata_c;
    assign m0.rlast = s.rlast;
    assign m1.rlast = s.rlast;
    assign m0.rresp = s.rresp;
    assign m1.rresp = s.rresp;
    assign m0.rid   = s.rid[ID_WIDTH-1:0];
    assign m1.rid   = s.rid[ID_WIDTH-1:0];

    // Burst sequencing: grant in IDLE, hold AR in ADDR, follow R beats in DATA.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            s_arvalid_q <= 1'b0;
            s_araddr_q  <= '0;
            s_arlen_q   <= '0;
            s_arsize_q  <= '0;
            s_arburst_q <= '0;
            s_arid_q    <= '0;
            grant       <= 1'b1;
            busy        <= 1'b0;
            rid_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_c) begin
                        s_arvalid_q <= 1'b1;
                        s_araddr_q  <= sel_araddr_c;
                        s_arlen_q   <= sel_arlen_c;
                        s_arsize_q  <= sel_arsize_c;
                        s_arburst_q <= sel_arburst_c;
                        s_arid_q    <= {winner_c, sel_arid_c};
                        grant       <= winner_c;
                        busy        <= 1'b1;
                        state       <= ADDR;
                    end
                end
                ADDR: begin
                    if (s.arready) begin
                        s_arvalid_q <= 1'b0;
                        state       <= DATA;
                    end
                end
                DATA: begin
                    if (r_beat_c && (s.rid[ID_WIDTH] != grant)) begin
                        rid_err <= 1'b1;
                    end
                    if (r_beat_c && s.rlast) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    s_arvalid_q <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: round-robin instance (dut_a) with a data scoreboard and a
// fixed-priority instance (dut_p) checked for grant order.
module tb_axi_rd_arbiter;
    logic clk = 1'b0;
    logic reset;
    logic grant_a, busy_a, rid_err_a;
    logic grant_p, busy_p, rid_err_p;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        id;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];
    int    glog[$];
    int    plog[$];
    int    beats0 = 0, beats1 = 0;

    int          rem0 = 0, rem1 = 0, prem0 = 0, prem1 = 0;
    logic [31:0] base0 = '0, base1 = '0;
    logic [7:0]  len0 = '0, len1 = '0;
    logic        id0 = 1'b0, id1 = 1'b0;
    logic        flip_a = 1'b0;
    logic        rdy0;

    axi_rd_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(1)) ma0 ();
    axi_rd_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(1)) ma1 ();
    axi_rd_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(2)) sa ();
    axi_rd_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(1)) mp0 ();
    axi_rd_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(1)) mp1 ();
    axi_rd_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(2)) sp ();

    axi_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(1), .PRIORITY_M0(0)) dut_a (
        .clk(clk), .reset(reset), .m0(ma0), .m1(ma1), .s(sa),
        .grant(grant_a), .busy(busy_a), .rid_err(rid_err_a)
    );

    axi_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(1), .PRIORITY_M0(1)) dut_p (
        .clk(clk), .reset(reset), .m0(mp0), .m1(mp1), .s(sp),
        .grant(grant_p), .busy(busy_p), .rid_err(rid_err_p)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pop_grant(input string tag, input int exp);
        int g;
        g = 99;
        if (glog.size() != 0) g = glog.pop_front();
        check(tag, 64'(g), 64'(exp));
    endtask

    // Wait until all requests were accepted and all expected beats delivered.
    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || rem0 != 0 || rem1 != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 64'(n >= 300), 64'(0));
        @(negedge clk);
        @(negedge clk);
        check({tag, "_idle"}, 64'(busy_a), 64'(0));
    endtask

    // Request generators for dut_a: issue remN bursts, push expected beats on acceptance.
    initial begin : a_gen
        bit f0, f1;
        ma0.arvalid = 1'b0; ma0.araddr = '0; ma0.arlen = '0; ma0.arsize = 3'd2;
        ma0.arburst = 2'b01; ma0.arid = '0;
        ma1.arvalid = 1'b0; ma1.araddr = '0; ma1.arlen = '0; ma1.arsize = 3'd2;
        ma1.arburst = 2'b01; ma1.arid = '0;
        forever begin
            @(negedge clk);
            f0 = (ma0.arvalid === 1'b1) && (ma0.arready === 1'b1);
            f1 = (ma1.arvalid === 1'b1) && (ma1.arready === 1'b1);
            if (f0) begin
                for (int i = 0; i <= int'(ma0.arlen); i++)
                    q0.push_back('{data: ma0.araddr + 32'(i) * 32'd4, last: (i == int'(ma0.arlen)), id: ma0.arid});
                glog.push_back(0);
            end
            if (f1) begin
                for (int i = 0; i <= int'(ma1.arlen); i++)
                    q1.push_back('{data: ma1.araddr + 32'(i) * 32'd4, last: (i == int'(ma1.arlen)), id: ma1.arid});
                glog.push_back(1);
            end
            @(posedge clk);
            #1;
            if (f0) begin rem0--; ma0.araddr = ma0.araddr + 32'h40; end
            else if (!ma0.arvalid) ma0.araddr = base0;
            if (f1) begin rem1--; ma1.araddr = ma1.araddr + 32'h40; end
            else if (!ma1.arvalid) ma1.araddr = base1;
            ma0.arvalid = (rem0 > 0); ma0.arlen = len0; ma0.arid = id0;
            ma1.arvalid = (rem1 > 0); ma1.arlen = len1; ma1.arid = id1;
        end
    end

    // Memory model for dut_a: beat data = burst address + 4*beat, optional ID top-bit flip.
    initial begin : a_sub
        bit          arf, rf, rst_s, act;
        logic [31:0] naddr, addr;
        logic [7:0]  nlen, len, beat;
        logic [1:0]  nid, id;
        act = 0; addr = '0; len = '0; beat = '0; id = '0;
        sa.arready = 1'b0; sa.rvalid = 1'b0; sa.rdata = '0; sa.rlast = 1'b0; sa.rid = '0; sa.rresp = '0;
        forever begin
            @(negedge clk);
            rst_s = (reset === 1'b1);
            arf   = (sa.arvalid === 1'b1) && (sa.arready === 1'b1);
            rf    = (sa.rvalid === 1'b1) && (sa.rready === 1'b1);
            naddr = sa.araddr; nlen = sa.arlen; nid = sa.arid;
            @(posedge clk);
            #1;
            if (rst_s) act = 0;
            else begin
                if (rf) begin
                    if (beat == len) act = 0;
                    else beat++;
                end
                if (arf) begin act = 1; addr = naddr; len = nlen; id = nid; beat = '0; end
            end
            sa.arready = 1'b1;
            sa.rvalid  = act;
            sa.rdata   = addr + 32'(beat) * 32'd4;
            sa.rlast   = (beat == len);
            sa.rid     = id ^ {flip_a, 1'b0};
            sa.rresp   = 2'b00;
        end
    end

    // Scoreboard: every beat a manager accepts must be the next one it is owed.
    initial begin : a_mon
        beat_t e;
        forever begin
            @(negedge clk);
            if (ma0.rvalid === 1'b1 && ma0.rready === 1'b1) begin
                beats0++;
                if (q0.size() == 0) check("m0_stray_beat", 64'(ma0.rdata), 64'hFFFF_FFFF_FFFF_FFFF);
                else begin
                    e = q0.pop_front();
                    check("m0_rdata", 64'(ma0.rdata), 64'(e.data));
                    check("m0_rlast", 64'(ma0.rlast), 64'(e.last));
                    check("m0_rid", 64'(ma0.rid), 64'(e.id));
                end
            end
            if (ma1.rvalid === 1'b1 && ma1.rready === 1'b1) begin
                beats1++;
                if (q1.size() == 0) check("m1_stray_beat", 64'(ma1.rdata), 64'hFFFF_FFFF_FFFF_FFFF);
                else begin
                    e = q1.pop_front();
                    check("m1_rdata", 64'(ma1.rdata), 64'(e.data));
                    check("m1_rlast", 64'(ma1.rlast), 64'(e.last));
                    check("m1_rid", 64'(ma1.rid), 64'(e.id));
                end
            end
        end
    end

    // Request generator for dut_p: logs grant order only.
    initial begin : p_gen
        bit f0, f1;
        mp0.arvalid = 1'b0; mp0.araddr = 32'hA000; mp0.arlen = '0; mp0.arsize = 3'd2;
        mp0.arburst = 2'b01; mp0.arid = 1'b0; mp0.rready = 1'b1;
        mp1.arvalid = 1'b0; mp1.araddr = 32'hB000; mp1.arlen = '0; mp1.arsize = 3'd2;
        mp1.arburst = 2'b01; mp1.arid = 1'b1; mp1.rready = 1'b1;
        forever begin
            @(negedge clk);
            f0 = (mp0.arvalid === 1'b1) && (mp0.arready === 1'b1);
            f1 = (mp1.arvalid === 1'b1) && (mp1.arready === 1'b1);
            if (f0) plog.push_back(0);
            if (f1) plog.push_back(1);
            @(posedge clk);
            #1;
            if (f0) prem0--;
            if (f1) prem1--;
            mp0.arvalid = (prem0 > 0);
            mp1.arvalid = (prem1 > 0);
        end
    end

    // Memory model for dut_p.
    initial begin : p_sub
        bit          arf, rf, rst_s, act;
        logic [31:0] naddr, addr;
        logic [7:0]  nlen, len, beat;
        logic [1:0]  nid, id;
        act = 0; addr = '0; len = '0; beat = '0; id = '0;
        sp.arready = 1'b0; sp.rvalid = 1'b0; sp.rdata = '0; sp.rlast = 1'b0; sp.rid = '0; sp.rresp = '0;
        forever begin
            @(negedge clk);
            rst_s = (reset === 1'b1);
            arf   = (sp.arvalid === 1'b1) && (sp.arready === 1'b1);
            rf    = (sp.rvalid === 1'b1) && (sp.rready === 1'b1);
            naddr = sp.araddr; nlen = sp.arlen; nid = sp.arid;
            @(posedge clk);
            #1;
            if (rst_s) act = 0;
            else begin
                if (rf) begin
                    if (beat == len) act = 0;
                    else beat++;
                end
                if (arf) begin act = 1; addr = naddr; len = nlen; id = nid; beat = '0; end
            end
            sp.arready = 1'b1;
            sp.rvalid  = act;
            sp.rdata   = addr + 32'(beat) * 32'd4;
            sp.rlast   = (beat == len);
            sp.rid     = id;
            sp.rresp   = 2'b00;
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n, b0s, b1s;
        reset = 1'b1;
        ma0.rready = 1'b1;
        ma1.rready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state
        check("rst_grant", 64'(grant_a), 64'(1));
        check("rst_busy", 64'(busy_a), 64'(0));
        check("rst_rid_err", 64'(rid_err_a), 64'(0));
        check("rst_s_arvalid", 64'(sa.arvalid), 64'(0));
        check("rst_s_rready", 64'(sa.rready), 64'(0));
        check("rst_s_araddr", 64'(sa.araddr), 64'(0));
        check("rst_s_arid", 64'(sa.arid), 64'(0));
        check("rst_m0_rvalid", 64'(ma0.rvalid), 64'(0));
        check("rst_p_grant", 64'(grant_p), 64'(1));
        @(posedge clk);
        #1 reset = 1'b0;

        // Round-robin: both request continuously, single-beat bursts
        len0 = 8'd0; len1 = 8'd0; base0 = 32'h2000; base1 = 32'h3000;
        id0 = 1'b0; id1 = 1'b1;
        rem0 = 2; rem1 = 2;
        drain("rr");
        pop_grant("rr_grant0", 0);
        pop_grant("rr_grant1", 1);
        pop_grant("rr_grant2", 0);
        pop_grant("rr_grant3", 1);
        check("rr_last_grant", 64'(grant_a), 64'(1));

        // Fixed priority: m0 wins every tie while it keeps requesting
        prem0 = 3; prem1 = 3;
        n = 0;
        while (plog.size() < 6 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("prio_timeout", 64'(n >= 300), 64'(0));
        for (int i = 0; i < 6; i++) begin
            int g;
            g = 99;
            if (plog.size() != 0) g = plog.pop_front();
            check($sformatf("prio_grant%0d", i), 64'(g), 64'((i < 3) ? 0 : 1));
        end
        repeat (6) @(negedge clk);
        check("prio_idle", 64'(busy_p), 64'(0));
        check("prio_rid_err", 64'(rid_err_p), 64'(0));

        // Single m0 burst, arlen=3
        b0s = beats0; b1s = beats1;
        base0 = 32'h1000; len0 = 8'd3; id0 = 1'b1; rem0 = 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ma0.arvalid === 1'b1 && ma0.arready === 1'b1) && n < 50);
        check("t1_m0_arready", 64'(ma0.arready), 64'(1));
        check("t1_m1_arready", 64'(ma1.arready), 64'(0));
        @(negedge clk);
        check("t1_s_arvalid", 64'(sa.arvalid), 64'(1));
        check("t1_s_araddr", 64'(sa.araddr), 64'h1000);
        check("t1_s_arlen", 64'(sa.arlen), 64'(3));
        check("t1_s_arid", 64'(sa.arid), 64'(2'b01));
        check("t1_grant", 64'(grant_a), 64'(0));
        check("t1_busy", 64'(busy_a), 64'(1));
        check("t1_arready_pulse", 64'(ma0.arready), 64'(0));
        drain("t1");
        check("t1_m0_beats", 64'(beats0 - b0s), 64'(4));
        check("t1_m1_beats", 64'(beats1 - b1s), 64'(0));
        pop_grant("t1_glog", 0);

        // Backpressure on an 8-beat m0 burst; m1 request raised mid-burst must wait
        b0s = beats0; b1s = beats1;
        base0 = 32'h4000; len0 = 8'd7; id0 = 1'b0; rem0 = 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ma0.arvalid === 1'b1 && ma0.arready === 1'b1) && n < 50);
        check("bp_wait", 64'(n >= 50), 64'(0));
        @(negedge clk);
        rdy0 = 1'b1;
        for (int c = 0; c < 40 && (beats0 - b0s) < 8; c++) begin
            @(posedge clk);
            #1;
            ma0.rready = rdy0;
            if (c == 2) begin
                base1 = 32'h5000; len1 = 8'd0; id1 = 1'b1; rem1 = 1;
            end
            @(negedge clk);
            if (busy_a) begin
                check("bp_s_rready", 64'(sa.rready), 64'(rdy0));
                check("bp_m1_held", 64'(ma1.arready), 64'(0));
            end
            rdy0 = ~rdy0;
        end
        @(posedge clk);
        #1 ma0.rready = 1'b1;
        drain("bp");
        check("bp_m0_beats", 64'(beats0 - b0s), 64'(8));
        check("bp_m1_beats", 64'(beats1 - b1s), 64'(1));
        pop_grant("bp_glog0", 0);
        pop_grant("bp_glog1", 1);

        // Reset in the middle of an 8-beat burst
        b0s = beats0;
        base0 = 32'h6000; len0 = 8'd7; id0 = 1'b1; rem0 = 1;
        n = 0;
        while ((beats0 - b0s) < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("mid_reach_beat2", 64'(n >= 100), 64'(0));
        check("mid_busy_before", 64'(busy_a), 64'(1));
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_s_arvalid", 64'(sa.arvalid), 64'(0));
        check("mid_s_rready", 64'(sa.rready), 64'(0));
        check("mid_m0_rvalid", 64'(ma0.rvalid), 64'(0));
        check("mid_m1_rvalid", 64'(ma1.rvalid), 64'(0));
        check("mid_grant", 64'(grant_a), 64'(1));
        check("mid_busy", 64'(busy_a), 64'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        q0.delete(); q1.delete(); glog.delete();
        b1s = beats1;
        base1 = 32'h7000; len1 = 8'd1; id1 = 1'b0; rem1 = 1;
        drain("post_rst");
        check("post_rst_m1_beats", 64'(beats1 - b1s), 64'(2));
        check("post_rst_grant", 64'(grant_a), 64'(1));
        pop_grant("post_rst_glog", 1);

        // Sticky rid_err on a mismatching returned ID
        check("rid_err_clean", 64'(rid_err_a), 64'(0));
        flip_a = 1'b1;
        base0 = 32'h8000; len0 = 8'd0; id0 = 1'b0; rem0 = 1;
        drain("flip");
        check("rid_err_set", 64'(rid_err_a), 64'(1));
        flip_a = 1'b0;
        base0 = 32'h8100; rem0 = 1;
        drain("flip2");
        check("rid_err_sticky", 64'(rid_err_a), 64'(1));
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rid_err_cleared", 64'(rid_err_a), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
